// File: rtl/fsb_cycle_ctl_if.sv
// Bus-cycle signals between the select decoder / I/O-bus bridge and the
// front-side-bus cycle controller. The master side drives the cycle and
// select inputs plus the bridge acknowledge; the slave side is the controller.
interface fsb_cycle_ctl_if;
    logic BACT;
    logic RAMCS;
    logic ROMCS;
    logic IOCS;
    logic IOPWCS;
    logic IOACK;
    logic nDTACK;
    logic nBERR;
    logic IOREQ;
    logic IOPW;
    logic PWBusy;

    modport master (
        output BACT, RAMCS, ROMCS, IOCS, IOPWCS, IOACK,
        input  nDTACK, nBERR, IOREQ, IOPW, PWBusy
    );

    modport slave (
        input  BACT, RAMCS, ROMCS, IOCS, IOPWCS, IOACK,
        output nDTACK, nBERR, IOREQ, IOPW, PWBusy
    );
endinterface

// File: rtl/fsb_cycle_ctl.sv
// Front-side-bus cycle controller for 68HC000 address-strobe cycles.
// Generates nDTACK/nBERR with RAM/ROM wait states, hands I/O cycles to the
// I/O-bus bridge (level IOREQ, pulse IOACK) and holds a one-entry
// posted-write slot. The posted-write path is built only when the macro
// FSB_POSTWR_EN is defined; otherwise IOPWCS is ignored and IOPW/PWBusy are 0.
module fsb_cycle_ctl #(
    parameter int unsigned RAM_WS  = 0,
    parameter int unsigned ROM_WS  = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RES,
    fsb_cycle_ctl_if.slave    bus
);
    localparam logic [7:0] RAM_WS_C  = 8'(RAM_WS);
    localparam logic [7:0] ROM_WS_C  = 8'(ROM_WS);
    localparam logic [7:0] TO_LAST_C = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WS     = 3'd1,
        S_IOWAIT = 3'd2,
`ifdef FSB_POSTWR_EN
        S_PWWAIT = 3'd3,
`endif
        S_ACK    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ioreq_q, ioreq_d;
    logic       ndtack_q, ndtack_d;
    logic       nberr_q, nberr_d;
    logic       iopw_q;
    logic       pwbusy_q;
    logic       accept_pw;

`ifdef FSB_POSTWR_EN
    logic       iopw_d;
    logic       pwbusy_d;
    logic       pw_slot_free;

    // The slot counts as free when its acknowledge arrives this very cycle.
    assign pw_slot_free = !pwbusy_q || bus.IOACK;
`else
    logic       unused_iopwcs;

    assign unused_iopwcs = bus.IOPWCS;
    assign iopw_q        = 1'b0;
    assign pwbusy_q      = 1'b0;
`endif

    // Next-state, counter and handshake logic for one bus cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_pw = 1'b0;
        // A request is held until the bridge acknowledges it, whatever the cycle does.
        ioreq_d   = ioreq_q & ~bus.IOACK;
`ifdef FSB_POSTWR_EN
        iopw_d    = iopw_q & ~bus.IOACK;
        pwbusy_d  = pwbusy_q & ~bus.IOACK;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.BACT) begin
`ifdef FSB_POSTWR_EN
                    if (bus.IOPWCS) begin
                        if (pw_slot_free) begin
                            accept_pw = 1'b1;
                        end else begin
                            state_d = S_PWWAIT;
                        end
                    end else
`endif
                    if (bus.IOCS) begin
                        // Stale or posted request outstanding: wait here until it clears.
                        if (!ioreq_q && !pwbusy_q) begin
                            ioreq_d = 1'b1;
`ifdef FSB_POSTWR_EN
                            iopw_d  = 1'b0;
`endif
                            cnt_d   = 8'd0;
                            state_d = S_IOWAIT;
                        end
                    end else if (bus.ROMCS) begin
                        cnt_d   = ROM_WS_C;
                        state_d = (ROM_WS_C == 8'd0) ? S_ACK : S_WS;
                    end else if (bus.RAMCS) begin
                        cnt_d   = RAM_WS_C;
                        state_d = (RAM_WS_C == 8'd0) ? S_ACK : S_WS;
                    end else begin
                        // Unmapped access: floating-bus read, acknowledged normally.
                        state_d = S_ACK;
                    end
                end
            end

            S_WS: begin
                if (!bus.BACT) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_ACK;
                    end
                end
            end

            S_IOWAIT: begin
                if (!bus.BACT) begin
                    state_d = S_IDLE;
                end else if (bus.IOACK) begin
                    state_d = S_ACK;
                end else if (cnt_q == TO_LAST_C) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

`ifdef FSB_POSTWR_EN
            S_PWWAIT: begin
                if (!bus.BACT) begin
                    state_d = S_IDLE;
                end else if (bus.IOACK) begin
                    accept_pw = 1'b1;
                end
            end
`endif

            S_ACK, S_ERR: begin
                if (!bus.BACT) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

`ifdef FSB_POSTWR_EN
        // Taking the write overrides any acknowledge-driven clear, so IOREQ stays high.
        if (accept_pw) begin
            pwbusy_d = 1'b1;
            ioreq_d  = 1'b1;
            iopw_d   = 1'b1;
            state_d  = S_ACK;
        end
`endif

        ndtack_d = (state_d != S_ACK);
        nberr_d  = (state_d != S_ERR);
    end

    // State, counter and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            ioreq_q  <= 1'b0;
            ndtack_q <= 1'b1;
            nberr_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ioreq_q  <= ioreq_d;
            ndtack_q <= ndtack_d;
            nberr_q  <= nberr_d;
        end
    end

`ifdef FSB_POSTWR_EN
    // Posted-write slot occupancy and write qualifier.
    always_ff @(posedge CLK) begin
        if (RES) begin
            iopw_q   <= 1'b0;
            pwbusy_q <= 1'b0;
        end else begin
            iopw_q   <= iopw_d;
            pwbusy_q <= pwbusy_d;
        end
    end
`endif

    assign bus.nDTACK = ndtack_q;
    assign bus.nBERR  = nberr_q;
    assign bus.IOREQ  = ioreq_q;
    assign bus.IOPW   = iopw_q;
    assign bus.PWBusy = pwbusy_q;
endmodule

// File: tb/tb_fsb_cycle_ctl.sv
// Directed bench for fsb_cycle_ctl with RAM_WS=2, ROM_WS=1, TIMEOUT=8.
// Inputs change 1 time unit after a rising edge; outputs are read at the same
// point, so a value read after edge k is the registered result of edge k.
module tb_fsb_cycle_ctl;
    logic CLK;
    logic RES;
    int   n_assert;
    int   n_fail;

    fsb_cycle_ctl_if bus_if ();

    fsb_cycle_ctl #(
        .RAM_WS  (2),
        .ROM_WS  (1),
        .TIMEOUT (8)
    ) dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.BACT   = 1'b0;
        bus_if.RAMCS  = 1'b0;
        bus_if.ROMCS  = 1'b0;
        bus_if.IOCS   = 1'b0;
        bus_if.IOPWCS = 1'b0;
        bus_if.IOACK  = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle_inputs();
        RES = 1'b1;
        step();
        step();
        chk("rst_ndtack", bus_if.nDTACK, 1'b1);
        chk("rst_nberr",  bus_if.nBERR,  1'b1);
        chk("rst_ioreq",  bus_if.IOREQ,  1'b0);
        chk("rst_iopw",   bus_if.IOPW,   1'b0);
        chk("rst_pwbusy", bus_if.PWBusy, 1'b0);

        // Reset in the middle of an I/O wait.
        RES = 1'b0;
        bus_if.BACT = 1'b1;
        bus_if.IOCS = 1'b1;
        step();
        chk("midrst_ioreq_up", bus_if.IOREQ, 1'b1);
        step();
        step();
        RES = 1'b1;
        step();
        chk("midrst_ioreq",  bus_if.IOREQ,  1'b0);
        chk("midrst_ndtack", bus_if.nDTACK, 1'b1);
        chk("midrst_nberr",  bus_if.nBERR,  1'b1);
        RES = 1'b0;
        idle_inputs();
        step();

        // RAM cycle, two wait states.
        bus_if.BACT  = 1'b1;
        bus_if.RAMCS = 1'b1;
        step();
        chk("ram_ws_n0", bus_if.nDTACK, 1'b1);
        step();
        chk("ram_ws_n1", bus_if.nDTACK, 1'b1);
        step();
        chk("ram_ack",   bus_if.nDTACK, 1'b0);
        chk("ram_nberr", bus_if.nBERR,  1'b1);
        step();
        chk("ram_hold",  bus_if.nDTACK, 1'b0);
        idle_inputs();
        step();
        chk("ram_release", bus_if.nDTACK, 1'b1);

        // ROM cycle, one wait state.
        bus_if.BACT  = 1'b1;
        bus_if.ROMCS = 1'b1;
        step();
        chk("rom_ws_n0", bus_if.nDTACK, 1'b1);
        step();
        chk("rom_ack",   bus_if.nDTACK, 1'b0);
        idle_inputs();
        step();
        chk("rom_release", bus_if.nDTACK, 1'b1);

        // Unmapped cycle acknowledged immediately.
        bus_if.BACT = 1'b1;
        step();
        chk("unmapped_ack",   bus_if.nDTACK, 1'b0);
        chk("unmapped_nberr", bus_if.nBERR,  1'b1);
        idle_inputs();
        step();

        // I/O cycle acknowledged after seven cycles.
        bus_if.BACT = 1'b1;
        bus_if.IOCS = 1'b1;
        step();
        chk("io_req_up",   bus_if.IOREQ,  1'b1);
        chk("io_iopw",     bus_if.IOPW,   1'b0);
        chk("io_wait_dt",  bus_if.nDTACK, 1'b1);
        for (int i = 0; i < 5; i++) step();
        chk("io_req_held", bus_if.IOREQ,  1'b1);
        chk("io_wait_be",  bus_if.nBERR,  1'b1);
        bus_if.IOACK = 1'b1;
        step();
        bus_if.IOACK = 1'b0;
        chk("io_ack_dt",   bus_if.nDTACK, 1'b0);
        chk("io_req_drop", bus_if.IOREQ,  1'b0);
        chk("io_ack_be",   bus_if.nBERR,  1'b1);
        idle_inputs();
        step();
        chk("io_release",  bus_if.nDTACK, 1'b1);

        // I/O timeout, then a late acknowledge.
        bus_if.BACT = 1'b1;
        bus_if.IOCS = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("to_before",    bus_if.nBERR,  1'b1);
        step();
        chk("to_berr",      bus_if.nBERR,  1'b0);
        chk("to_no_dtack",  bus_if.nDTACK, 1'b1);
        chk("to_req_held",  bus_if.IOREQ,  1'b1);
        idle_inputs();
        step();
        chk("to_release",   bus_if.nBERR,  1'b1);
        chk("to_req_after", bus_if.IOREQ,  1'b1);

        // New I/O cycle waits while the stale request is outstanding.
        bus_if.BACT = 1'b1;
        bus_if.IOCS = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("stale_no_berr", bus_if.nBERR,  1'b1);
        chk("stale_no_dt",   bus_if.nDTACK, 1'b1);
        bus_if.IOACK = 1'b1;
        step();
        bus_if.IOACK = 1'b0;
        chk("late_ack_drop", bus_if.IOREQ,  1'b0);
        step();
        chk("stale_reissue", bus_if.IOREQ,  1'b1);
        bus_if.IOACK = 1'b1;
        step();
        bus_if.IOACK = 1'b0;
        chk("stale_ack_dt",  bus_if.nDTACK, 1'b0);
        idle_inputs();
        step();

        // Aborted RAM cycle in wait states.
        bus_if.BACT  = 1'b1;
        bus_if.RAMCS = 1'b1;
        step();
        idle_inputs();
        step();
        chk("abort_ws_dt0", bus_if.nDTACK, 1'b1);
        step();
        chk("abort_ws_dt1", bus_if.nDTACK, 1'b1);

        // Aborted I/O cycle keeps its request until acknowledged.
        bus_if.BACT = 1'b1;
        bus_if.IOCS = 1'b1;
        step();
        idle_inputs();
        step();
        chk("abort_io_req", bus_if.IOREQ,  1'b1);
        chk("abort_io_dt",  bus_if.nDTACK, 1'b1);
        bus_if.IOACK = 1'b1;
        step();
        bus_if.IOACK = 1'b0;
        chk("abort_io_drop", bus_if.IOREQ,  1'b0);
        chk("abort_io_dt2",  bus_if.nDTACK, 1'b1);
        step();

`ifdef FSB_POSTWR_EN
        // First posted write: acknowledged at once.
        bus_if.BACT   = 1'b1;
        bus_if.IOPWCS = 1'b1;
        step();
        chk("pw1_dt",     bus_if.nDTACK, 1'b0);
        chk("pw1_req",    bus_if.IOREQ,  1'b1);
        chk("pw1_iopw",   bus_if.IOPW,   1'b1);
        chk("pw1_busy",   bus_if.PWBusy, 1'b1);
        idle_inputs();
        step();
        chk("pw1_release", bus_if.nDTACK, 1'b1);
        // Second posted write waits for the slot.
        bus_if.BACT   = 1'b1;
        bus_if.IOPWCS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pw2_wait_dt",  bus_if.nDTACK, 1'b1);
            chk("pw2_wait_req", bus_if.IOREQ,  1'b1);
        end
        bus_if.IOACK = 1'b1;
        step();
        bus_if.IOACK = 1'b0;
        chk("pw2_dt",   bus_if.nDTACK, 1'b0);
        chk("pw2_req",  bus_if.IOREQ,  1'b1);
        chk("pw2_iopw", bus_if.IOPW,   1'b1);
        chk("pw2_busy", bus_if.PWBusy, 1'b1);
        idle_inputs();
        step();
        // I/O read behind a pending posted write waits for the slot.
        bus_if.BACT = 1'b1;
        bus_if.IOCS = 1'b1;
        step();
        step();
        chk("pwio_wait_dt", bus_if.nDTACK, 1'b1);
        bus_if.IOACK = 1'b1;
        step();
        bus_if.IOACK = 1'b0;
        chk("pw_free_busy", bus_if.PWBusy, 1'b0);
        chk("pw_free_req",  bus_if.IOREQ,  1'b0);
        chk("pw_free_iopw", bus_if.IOPW,   1'b0);
        step();
        chk("pwio_req",  bus_if.IOREQ, 1'b1);
        chk("pwio_iopw", bus_if.IOPW,  1'b0);
        bus_if.IOACK = 1'b1;
        step();
        bus_if.IOACK = 1'b0;
        chk("pwio_dt", bus_if.nDTACK, 1'b0);
        idle_inputs();
        step();
`else
        // Posted-write select ignored: RAM path with RAM wait states.
        bus_if.BACT   = 1'b1;
        bus_if.IOPWCS = 1'b1;
        bus_if.RAMCS  = 1'b1;
        step();
        chk("nopw_n0",   bus_if.nDTACK, 1'b1);
        chk("nopw_req0", bus_if.IOREQ,  1'b0);
        step();
        chk("nopw_n1",   bus_if.nDTACK, 1'b1);
        step();
        chk("nopw_ack",  bus_if.nDTACK, 1'b0);
        chk("nopw_req",  bus_if.IOREQ,  1'b0);
        chk("nopw_iopw", bus_if.IOPW,   1'b0);
        chk("nopw_busy", bus_if.PWBusy, 1'b0);
        idle_inputs();
        step();
        chk("nopw_release", bus_if.nDTACK, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fsb_cycle_ctl.md
# fsb_cycle_ctl

Front-side-bus cycle controller that consumes the chip-select decode for every 68HC000 address-strobe cycle. It runs a per-cycle state machine that generates `nDTACK`/`nBERR` with programmable RAM/ROM wait states. It hands I/O cycles to the I/O-bus bridge over a level REQ / pulse ACK handshake and holds a one-entry posted-write slot. It sits directly downstream of the select decoder and upstream of the I/O-bus bridge.

## Interface
- `RAM_WS`, 0: wait states before DTACK on RAM cycles (0–15).
- `ROM_WS`, 1: wait states before DTACK on ROM cycles (0–15).
- `TIMEOUT`, 255: I/O wait cycles before bus error (1–255; counter is 8 bits).
- `CLK` in 1: FSB clock; all logic on its rising edge.
- `RES` in 1: synchronous, active-high reset.
- `BACT` in 1: AS cycle active; high from cycle start until AS negates.
- `RAMCS` in 1: RAM select.
- `ROMCS` in 1: ROM select.
- `IOCS` in 1: I/O-bus select.
- `IOPWCS` in 1: posted-write candidate (low RAM write, already qualified with write).
- `IOACK` in 1: one-cycle pulse from bridge, already synchronised to `CLK`.
- `nDTACK` out 1: data acknowledge to CPU, active low.
- `nBERR` out 1: bus error to CPU, active low.
- `IOREQ` out 1: request to bridge, level.
- `IOPW` out 1: qualifies `IOREQ` as a posted write.
- `PWBusy` out 1: posted-write slot occupied.

## Operation
- Reset values: `nDTACK`=1, `nBERR`=1, `IOREQ`=0, `IOPW`=0, `PWBusy`=0. State is IDLE and all counters are 0.
- States: IDLE, WS, IOWAIT, PWWAIT, ACK, ERR.
- IDLE with `BACT`=1 decodes with priority IOPWCS > IOCS > ROMCS > RAMCS > none:
  - IOPWCS, `PWBusy`=0: set `PWBusy`, raise `IOREQ`+`IOPW`, go to ACK.
  - IOPWCS, `PWBusy`=1: go to PWWAIT.
  - IOCS: if `IOREQ` is already set (stale request), wait in IDLE. Otherwise raise `IOREQ` (`IOPW`=0) and go to IOWAIT. `IOREQ` is never raised while `PWBusy`=1; the cycle waits in IDLE until the slot is free.
  - ROMCS/RAMCS: load the wait counter with ROM_WS/RAM_WS. If 0, go to ACK; else go to WS.
  - None: go to ACK (floating-bus read, no error).
- WS: decrement the counter each cycle; on reaching 0, go to ACK.
- PWWAIT: when `IOACK`=1, behave as IDLE-IOPWCS with the slot free.
- IOWAIT: count cycles. `IOACK`=1 → ACK. Count reaches TIMEOUT → ERR. After a timeout, `IOREQ` stays high until the late `IOACK`.
- `IOREQ`/`IOPW` drop on the edge after `IOACK`=1.
- `PWBusy` clears on the edge after `IOACK` for the posted write.
- ACK drives `nDTACK`=0. ERR drives `nBERR`=0. Both are held until `BACT`=0, then deasserted on the next edge with return to IDLE.
- `BACT` falling in WS/IOWAIT/PWWAIT (aborted cycle): return to IDLE, no DTACK. A pending `IOREQ` is held until its `IOACK`.
- Simultaneous: `IOACK` clearing `PWBusy` in the same cycle a new IOPWCS cycle is decoded → new write accepted that edge, and `IOREQ` stays high continuously.
- `RES` mid-cycle: all outputs reach reset values on the next edge. The bridge is responsible for discarding its own in-flight request.

## Timing
- Cycle start seen at edge N: `nDTACK` low at N+1+WS (RAM/ROM), or N+1 for posted/unmapped.
- I/O: `IOREQ` high at N+1. `IOACK` sampled at edge M → `nDTACK` low at M+1.
- Timeout: `nBERR` low at N+1+TIMEOUT if no `IOACK`.
- `BACT` sampled low at edge K → `nDTACK`/`nBERR` high at K+1. A new cycle may be decoded from K+1.
- `nDTACK` and `nBERR` are never low simultaneously.

## Configuration
- `FSB_POSTWR_EN` defined: posted-write path as above.
- `FSB_POSTWR_EN` undefined:
  - IOPWCS is ignored in decode and the corresponding IOCS/RAMCS priority applies.
  - `IOPW` and `PWBusy` are tied 0.
  - PWWAIT is removed.

## Test plan
- Reset mid-IOWAIT (`IOREQ`=1) → next edge all outputs at reset values, state IDLE.
- RAM read, RAM_WS=2, `BACT` at edge 10 → `nDTACK` low at edge 13. `BACT` low at 20 → `nDTACK` high at 21.
- IOCS cycle with `IOACK` pulse at edge 17 (start 10) → `IOREQ` 11–17, `nDTACK` low at 18, no `nBERR`.
- IOCS with no `IOACK`, TIMEOUT=8, start at 10 → `nBERR` low at 19. `IOREQ` held; late `IOACK` at 40 → `IOREQ` low at 41.
- Two back-to-back posted writes, first `IOACK` at edge 25:
  - First write: `nDTACK` at start+1.
  - Second write: sits in PWWAIT until `IOACK`, then `nDTACK` at 26 with `IOREQ` continuously high.
- Build without `FSB_POSTWR_EN`, IOPWCS+RAMCS write → RAM path with RAM_WS timing; `IOREQ` never asserted.
